pc_counter: RTL and testbench



---
 rtl/pc_counter_if.sv | 27 ++
 rtl/pc_counter.sv | 114 +++++++++++
 tb/tb_pc_counter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pc_counter_if.sv
// Control/target inputs and PC/stack status outputs of the program counter.
// Plain wires only; no flow control, every request is consumed on the next edge.
interface pc_counter_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             clr;
  logic             load;
  logic             inc;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] out;
  logic             ret_empty;
  logic             ret_full;
  logic             err;
  logic             ovf;

  modport master (
    output in, clr, load, inc, call, ret,
    input  out, ret_empty, ret_full, err, ovf
  );

  modport slave (
    input  in, clr, load, inc, call, ret,
    output out, ret_empty, ret_full, err, ovf
  );
endinterface

// File: rtl/pc_counter.sv
// Program counter with LIFO return stack: clr > call > ret > load > inc > hold, one cycle latency, never stalls.
// Optional PC_OVF_TRAP_EN: inc at all-ones saturates and sets sticky ovf instead of wrapping.
module pc_counter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  pc_counter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic             push;
  logic             empty, full;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] ret_addr;
`ifdef PC_OVF_TRAP_EN
  logic             ovf_q, ovf_d;
`endif

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  // Below full the low count bits are the next free slot; top entry is one below.
  assign wr_idx   = cnt_q[AW-1:0];
  assign rd_idx   = wr_idx - AW'(1);
  assign ret_addr = pc_q + WIDTH'(1);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
`ifdef PC_OVF_TRAP_EN
    ovf_d = ovf_q;
`endif
    if (bus.clr) begin
      pc_d  = '0;
      cnt_d = '0;
      err_d = 1'b0;
`ifdef PC_OVF_TRAP_EN
      ovf_d = 1'b0;
`endif
    end else if (bus.call) begin
      pc_d = bus.in;
      if (full) begin
        err_d = 1'b1;
      end else begin
        push  = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (bus.ret) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        pc_d  = stk_q[rd_idx];
        cnt_d = cnt_q - CW'(1);
      end
    end else if (bus.load) begin
      pc_d = bus.in;
    end else if (bus.inc) begin
`ifdef PC_OVF_TRAP_EN
      if (&pc_q) begin
        ovf_d = 1'b1;
      end else begin
        pc_d = ret_addr;
      end
`else
      pc_d = ret_addr;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

`ifdef PC_OVF_TRAP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  // Storage is left unreset; only the count decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      stk_q[wr_idx] <= ret_addr;
    end
  end

  assign bus.out       = pc_q;
  assign bus.ret_empty = empty;
  assign bus.ret_full  = full;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_pc_counter.sv
// Directed bench for pc_counter: stimulus pushes expected state, a negedge monitor pops and compares.
module tb_pc_counter;
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_INC  = 5'b00001;
  localparam logic [4:0] C_LOAD = 5'b00010;
  localparam logic [4:0] C_RET  = 5'b00100;
  localparam logic [4:0] C_CALL = 5'b01000;
  localparam logic [4:0] C_CLR  = 5'b10000;
`ifdef PC_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [19:0] v;
  } exp_t;

  logic   clock;
  logic   reset_n;
  exp_t   exp_q[$];
  exp_t   cur;
  int     n_checks;
  int     n_fail;
  logic [19:0] act;

  pc_counter_if #(.WIDTH(16)) bus ();

  pc_counter #(.WIDTH(16), .DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push_exp(input string nm, input logic [15:0] eo, input logic ee,
                          input logic ef, input logic er, input logic eov);
    exp_t e;
    e.nm = nm;
    e.v  = {eo, ee, ef, er, eov};
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [4:0] ctl, input logic [15:0] d, input string nm,
                      input logic [15:0] eo, input logic ee, input logic ef,
                      input logic er, input logic eov);
    @(negedge clock);
    {bus.clr, bus.call, bus.ret, bus.load, bus.inc} = ctl;
    bus.in = d;
    @(posedge clock);
    push_exp(nm, eo, ee, ef, er, eov);
  endtask

  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      act = {bus.out, bus.ret_empty, bus.ret_full, bus.err, bus.ovf};
      n_checks++;
      if (act !== cur.v) begin
        n_fail++;
        $display("FAIL %s: got out=%h empty=%b full=%b err=%b ovf=%b, want out=%h empty=%b full=%b err=%b ovf=%b",
                 cur.nm, act[19:4], act[3], act[2], act[1], act[0],
                 cur.v[19:4], cur.v[3], cur.v[2], cur.v[1], cur.v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    {bus.clr, bus.call, bus.ret, bus.load, bus.inc} = C_NONE;
    bus.in   = '0;

    @(posedge clock);
    #1 push_exp("reset_init", 16'h0000, 1, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    step(C_LOAD, 16'h1234, "load_1234", 16'h1234, 1, 0, 0, 0);
    // Reset asserted between edges must show up before the next rising edge.
    @(posedge clock);
    #1 reset_n = 1'b0;
    push_exp("async_reset", 16'h0000, 1, 0, 0, 0);
    {bus.clr, bus.call, bus.ret, bus.load, bus.inc} = C_NONE;
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 1; i <= 5; i++)
      step(C_INC, 16'h0000, "inc_after_reset", 16'(i), 1, 0, 0, 0);

    step(C_LOAD | C_INC, 16'h0FA0, "load_over_inc", 16'h0FA0, 1, 0, 0, 0);
    step(C_INC,  16'h0000, "inc_0fa1",      16'h0FA1, 1, 0, 0, 0);
    step(C_NONE, 16'h5555, "hold",          16'h0FA1, 1, 0, 0, 0);

    step(C_LOAD, 16'h0010, "load_0010",     16'h0010, 1, 0, 0, 0);
    step(C_CALL, 16'h0200, "call_0200",     16'h0200, 0, 0, 0, 0);
    step(C_INC,  16'h0000, "inc_0201",      16'h0201, 0, 0, 0, 0);
    step(C_INC,  16'h0000, "inc_0202",      16'h0202, 0, 0, 0, 0);
    step(C_RET,  16'h0000, "ret_0011",      16'h0011, 1, 0, 0, 0);

    step(C_CALL, 16'h1000, "fill_call1",    16'h1000, 0, 0, 0, 0);
    step(C_CALL, 16'h2000, "fill_call2",    16'h2000, 0, 0, 0, 0);
    step(C_CALL, 16'h3000, "fill_call3",    16'h3000, 0, 0, 0, 0);
    step(C_CALL, 16'h4000, "fill_call4",    16'h4000, 0, 1, 0, 0);
    step(C_CALL, 16'h5000, "call_on_full",  16'h5000, 0, 1, 1, 0);
    step(C_RET,  16'h0000, "pop_3001",      16'h3001, 0, 0, 1, 0);
    step(C_RET,  16'h0000, "pop_2001",      16'h2001, 0, 0, 1, 0);
    step(C_RET,  16'h0000, "pop_1001",      16'h1001, 0, 0, 1, 0);
    step(C_RET,  16'h0000, "pop_0012",      16'h0012, 1, 0, 1, 0);
    step(C_RET,  16'h0000, "ret_on_empty",  16'h0012, 1, 0, 1, 0);
    step(C_CLR,  16'h0000, "clr_after_err", 16'h0000, 1, 0, 0, 0);

    step(C_RET | C_LOAD, 16'h7777, "ret_over_load", 16'h0000, 1, 0, 1, 0);
    step(C_CLR | C_LOAD | C_INC, 16'h7777, "clr_over_all", 16'h0000, 1, 0, 0, 0);

    step(C_LOAD, 16'hFFFF, "load_ffff",     16'hFFFF, 1, 0, 0, 0);
    step(C_INC,  16'h0000, "inc_at_ffff",   TRAP ? 16'hFFFF : 16'h0000, 1, 0, 0, TRAP);
    step(C_LOAD, 16'h0005, "load_after_ovf", 16'h0005, 1, 0, 0, TRAP);
    step(C_INC,  16'h0000, "ovf_sticky",    16'h0006, 1, 0, 0, TRAP);
    step(C_CLR,  16'h0000, "clr_ovf",       16'h0000, 1, 0, 0, 0);

    step(C_LOAD, 16'hFFFF, "load_ffff_2",   16'hFFFF, 1, 0, 0, 0);
    step(C_CALL, 16'h0010, "call_from_ffff", 16'h0010, 0, 0, 0, 0);
    step(C_RET,  16'h0000, "ret_wrapped",   16'h0000, 1, 0, 0, 0);

    step(C_LOAD, 16'h0100, "load_0100",     16'h0100, 1, 0, 0, 0);
    step(C_CALL, 16'h0400, "sim_call1",     16'h0400, 0, 0, 0, 0);
    step(C_CALL, 16'h0500, "sim_call2",     16'h0500, 0, 0, 0, 0);
    step(C_CALL | C_RET, 16'h0300, "call_ret_same", 16'h0300, 0, 0, 0, 0);
    step(C_CALL, 16'h0600, "count_was_3",   16'h0600, 0, 1, 0, 0);
    step(C_RET,  16'h0000, "sim_pop_0301",  16'h0301, 0, 0, 0, 0);
    step(C_RET,  16'h0000, "sim_pop_0501",  16'h0501, 0, 0, 0, 0);
    step(C_RET,  16'h0000, "sim_pop_0401",  16'h0401, 0, 0, 0, 0);
    step(C_CALL, 16'h0700, "refill_call",   16'h0700, 0, 0, 0, 0);
    step(C_CLR | C_CALL | C_RET, 16'h0300, "clr_call_ret", 16'h0000, 1, 0, 0, 0);

    @(negedge clock);
    {bus.clr, bus.call, bus.ret, bus.load, bus.inc} = C_NONE;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
